// File: rtl/xgriscv_sc.sv
// Single-cycle RV32I core with instruction memory, data memory and register file inside.
// Optional XGRISCV_TRACE_EN prints register writes and stores as they retire.
`timescale 1ns/1ps

module xgriscv_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic [AW-1:0] a,
    output logic [31:0]   rd
);
    reg [31:0] RAM [0:DEPTH-1];

    assign rd = RAM[a];
endmodule

module xgriscv_sc #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] pcW
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    logic [31:0] pc, pc4, next_pc;
    wire  [31:0] instr;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [31:0] rf   [0:31];
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [31:0] rs1v, rs2v, ls_addr, load_data, wdata;
    logic        reg_we, rf_we, mem_we, taken, imm_ok, reg_ok;
    logic        unused_addr_bits;

    xgriscv_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) U_imem (
        .a  (pc[IAW+1:2]),
        .rd (instr)
    );

    assign pcW    = pc;
    assign pc4    = pc + 32'd4;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1v = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2v = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    assign ls_addr          = rs1v + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign load_data        = dmem[ls_addr[DAW+1:2]];
    assign unused_addr_bits = ^{ls_addr[31:DAW+2], ls_addr[1:0]};

    // Shift encodings with stray funct7 bits are treated as unsupported (nop)
    assign imm_ok = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                    (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
    assign reg_ok = (funct7 == 7'h00) ||
                    (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        wdata   = pc4;
        next_pc = pc4;
        taken   = 1'b0;
        case (opcode)
            OP_LUI: begin
                reg_we = 1'b1;
                wdata  = imm_u;
            end
            OP_AUIPC: begin
                reg_we = 1'b1;
                wdata  = pc + imm_u;
            end
            OP_JAL: begin
                reg_we  = 1'b1;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    reg_we  = 1'b1;
                    next_pc = (rs1v + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  taken = (rs1v == rs2v);
                    3'b001:  taken = (rs1v != rs2v);
                    3'b100:  taken = ($signed(rs1v) <  $signed(rs2v));
                    3'b101:  taken = ($signed(rs1v) >= $signed(rs2v));
                    3'b110:  taken = (rs1v <  rs2v);
                    3'b111:  taken = (rs1v >= rs2v);
                    default: taken = 1'b0;
                endcase
                if (taken) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    reg_we = 1'b1;
                    wdata  = load_data;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) mem_we = 1'b1;
            end
            OP_IMM: begin
                if (imm_ok) begin
                    reg_we = 1'b1;
                    wdata  = alu(funct3, (funct3 == 3'b101) && instr[30], rs1v, imm_i);
                end
            end
            OP_REG: begin
                if (reg_ok) begin
                    reg_we = 1'b1;
                    wdata  = alu(funct3, instr[30], rs1v, rs2v);
                end
            end
            default: ;
        endcase
    end

    assign rf_we = reg_we && (rd != 5'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (rf_we) rf[rd] <= wdata;
        end
    end

    // Data memory keeps its contents across reset; stores are blocked while reset is held
    always_ff @(posedge clk) begin
        if (rstn && mem_we) dmem[ls_addr[DAW+1:2]] <= rs2v;
    end

`ifdef XGRISCV_TRACE_EN
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (rf_we)  $display("x%0d = %h", rd, wdata);
            if (mem_we) $display("mem[%h] = %h", ls_addr, rs2v);
        end
    end
`endif
endmodule

// File: tb/tb_xgriscv_sc.sv
// Bench for xgriscv_sc: directed program table, hand-written reset/branch sequences,
// and random programs checked against an instruction-level reference model.
`timescale 1ns/1ps

module tb_xgriscv_sc;
    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    wire  [31:0] pcW;

    int vectors     = 0;
    int miscompares = 0;

    xgriscv_sc dut (.clk(clk), .rstn(rstn), .pcW(pcW));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          kind;   // 0: register check, 1: data word check, 2: pc only
        int          idx;
        logic [31:0] val;
    } vec_t;

    vec_t        tbl [19];
    logic [31:0] prog [256];
    logic [31:0] m_x [32];
    logic [31:0] m_mem [256];
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    task automatic load_nops();
        for (int k = 0; k < 256; k++) dut.U_imem.RAM[k] = 32'h00000013;
    endtask

    task automatic run_until(input logic [31:0] target, input int budget);
        for (int k = 0; k < budget && pcW !== target; k++) step();
        check("reach_pc", pcW, target);
    endtask

    // Reference: one architectural instruction, straight from the ISA definition
    task automatic model_step(input logic [31:0] i, output int wr_rd);
        logic [31:0] a, b, ii, is, ib, ij, iu, v, nx;
        logic [4:0]  sh;
        logic        wr, tk;
        a  = m_x[i[19:15]];
        b  = m_x[i[24:20]];
        sh = i[24:20];
        ii = 32'($signed(i[31:20]));
        is = 32'($signed({i[31:25], i[11:7]}));
        ib = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        ij = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        iu = {i[31:12], 12'h000};
        nx = m_pc + 4;
        v  = 32'd0;
        wr = 1'b0;
        tk = 1'b0;
        case (i[6:0])
            7'h37: begin wr = 1; v = iu; end
            7'h17: begin wr = 1; v = m_pc + iu; end
            7'h6F: begin wr = 1; v = m_pc + 4; nx = m_pc + ij; end
            7'h67: begin wr = 1; v = m_pc + 4; nx = (a + ii) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (i[14:12])
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = (int'(a) <  int'(b));
                    3'd5: tk = (int'(a) >= int'(b));
                    3'd6: tk = (a <  b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) nx = m_pc + ib;
            end
            7'h03: begin wr = 1; v = m_mem[((a + ii) >> 2) & 255]; end
            7'h23: m_mem[((a + is) >> 2) & 255] = b;
            7'h13, 7'h33: begin
                logic [31:0] o;
                o  = (i[6:0] == 7'h13) ? ii : b;
                sh = (i[6:0] == 7'h13) ? sh : b[4:0];
                wr = 1;
                case (i[14:12])
                    3'd0: v = (i[6:0] == 7'h33 && i[30]) ? a - o : a + o;
                    3'd1: v = a << sh;
                    3'd2: v = (int'(a) < int'(o)) ? 32'd1 : 32'd0;
                    3'd3: v = (a < o) ? 32'd1 : 32'd0;
                    3'd4: v = a ^ o;
                    3'd5: v = i[30] ? 32'(int'(a) >>> sh) : a >> sh;
                    3'd6: v = a | o;
                    default: v = a & o;
                endcase
            end
            default: ;
        endcase
        wr_rd = -1;
        if (wr && i[11:7] != 5'd0) begin
            m_x[i[11:7]] = v;
            wr_rd = int'(i[11:7]);
        end
        m_pc = nx;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [12:0] bo;
        logic [20:0] jo;
        logic [31:0] r, res;
        logic        alt;
        int          c;
        c   = int'($urandom_range(0, 10));
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        sh  = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        alt = 1'($urandom_range(0, 1));
        r   = $urandom();
        case (c)
            0, 1: res = {1'b0, alt && (f3 == 3'd0 || f3 == 3'd5), 5'd0, rs2, rs1, f3, rd, 7'h33};
            2, 3: begin
                imm = r[11:0];
                if (f3 == 3'd1)      imm = {7'd0, sh};
                else if (f3 == 3'd5) imm = {1'b0, alt, 5'd0, sh};
                res = {imm, rs1, f3, rd, 7'h13};
            end
            4: res = {r[31:12], rd, alt ? 7'h37 : 7'h17};
            5: begin
                imm = 12'(256 + 4 * int'($urandom_range(0, 7)));
                res = {imm[11:5], rs2, 5'd0, 3'd2, imm[4:0], 7'h23};
            end
            6: begin
                imm = 12'(256 + 4 * int'($urandom_range(0, 7)));
                res = {imm, 5'd0, 3'd2, rd, 7'h03};
            end
            7: begin
                bo = 13'(4 * (int'($urandom_range(0, 23)) - 8));
                if (bo == 13'd0) bo = 13'd4;
                if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 ^ 3'b100;
                res = {bo[12], bo[10:5], rs2, rs1, f3, bo[4:1], bo[11], 7'h63};
            end
            8: begin
                jo = 21'(4 * (int'($urandom_range(0, 47)) - 16));
                if (jo == 21'd0) jo = 21'd8;
                res = {jo[20], jo[10:1], jo[11], jo[19:12], rd, 7'h6F};
            end
            9: begin
                imm = 12'(4 * int'($urandom_range(0, 255)));
                if (r[1:0] != 2'd0) rs1 = 5'd0;
                res = {imm, rs1, 3'd0, rd, 7'h67};
            end
            default: res = r[0] ? 32'h00000073 : 32'h0000000F;
        endcase
        return res;
    endfunction

    initial begin
        int w;
        logic [11:0] simm;

        // ---- reset and straight-line nops
        load_nops();
        #1 rstn = 1'b0;
        @(negedge clk);
        #0.005;
        check("rst_pcw_async", pcW, 32'h0);
        rstn = 1'b1;
        #1;
        check("rst_pcw", pcW, 32'h0);
        check("rst_instr", dut.instr, 32'h00000013);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("nop_pc%0d", k), pcW, 32'(4 * k));
        end

        // ---- lui sequence and taken beq
        hold_reset();
        load_nops();
        dut.U_imem.RAM[0] = 32'h00000293;
        dut.U_imem.RAM[1] = 32'h00000313;
        dut.U_imem.RAM[2] = 32'hFFFFF3B7;
        dut.U_imem.RAM[6] = 32'h16030A63;
        release_reset();
        for (int k = 0; k < 3; k++) step();
        check("lui_x5", dut.rf[5], 32'h0);
        check("lui_x6", dut.rf[6], 32'h0);
        check("lui_x7", dut.rf[7], 32'hFFFFF000);
        for (int k = 0; k < 3; k++) step();
        check("beq_at", pcW, 32'h18);
        step();
        check("beq_taken", pcW, 32'h18C);

        // ---- bne taken (x7 nonzero) then not taken (x7 zero)
        hold_reset();
        dut.U_imem.RAM[6]  = 32'h00000013;
        dut.U_imem.RAM[20] = 32'h16039A63;
        release_reset();
        run_until(32'h50, 40);
        step();
        check("bne_taken", pcW, 32'h1C4);
        hold_reset();
        dut.U_imem.RAM[2] = 32'h00000013;
        release_reset();
        run_until(32'h50, 40);
        step();
        check("bne_not_taken", pcW, 32'h54);

        // ---- reset in the middle of a program
        hold_reset();
        dut.U_imem.RAM[2]  = 32'hFFFFF3B7;
        dut.U_imem.RAM[20] = 32'h00000013;
        release_reset();
        run_until(32'h40, 40);
        check("mid_x7_before", dut.rf[7], 32'hFFFFF000);
        rstn = 1'b0;
        #1;
        check("mid_pcw_async", pcW, 32'h0);
        check("mid_x5", dut.rf[5], 32'h0);
        check("mid_x6", dut.rf[6], 32'h0);
        check("mid_x7", dut.rf[7], 32'h0);
        release_reset();
        check("mid_instr", dut.instr, 32'h00000293);
        step();
        check("mid_resume", pcW, 32'h4);

        // ---- directed program table
        tbl[0]  = '{32'hFFF00293, 32'h00, 0,  5, 32'hFFFFFFFF};
        tbl[1]  = '{32'h00502423, 32'h04, 1,  2, 32'hFFFFFFFF};
        tbl[2]  = '{32'h00802303, 32'h08, 0,  6, 32'hFFFFFFFF};
        tbl[3]  = '{32'h006033B3, 32'h0C, 0,  7, 32'h00000001};
        tbl[4]  = '{32'h008000EF, 32'h10, 0,  1, 32'h00000014};
        tbl[5]  = '{32'h12345437, 32'h18, 0,  8, 32'h12345000};
        tbl[6]  = '{32'h00001497, 32'h1C, 0,  9, 32'h0000101C};
        tbl[7]  = '{32'h00500513, 32'h20, 0, 10, 32'h00000005};
        tbl[8]  = '{32'h40A005B3, 32'h24, 0, 11, 32'hFFFFFFFB};
        tbl[9]  = '{32'h40445613, 32'h28, 0, 12, 32'h01234500};
        tbl[10] = '{32'h00A5D6B3, 32'h2C, 0, 13, 32'h07FFFFFF};
        tbl[11] = '{32'h00A5A733, 32'h30, 0, 14, 32'h00000001};
        tbl[12] = '{32'h00700013, 32'h34, 0,  0, 32'h00000000};
        tbl[13] = '{32'h043507E7, 32'h38, 0, 15, 32'h0000003C};
        tbl[14] = '{32'h00A5D463, 32'h48, 2,  0, 32'h00000000};
        tbl[15] = '{32'h00B56663, 32'h4C, 2,  0, 32'h00000000};
        tbl[16] = '{32'h00840833, 32'h58, 0, 16, 32'h2468A000};
        tbl[17] = '{32'h00000073, 32'h5C, 0, 16, 32'h2468A000};
        tbl[18] = '{32'h00000013, 32'h60, 2,  0, 32'h00000000};
        hold_reset();
        for (int k = 0; k < 256; k++) dut.U_imem.RAM[k] = 32'h0;
        foreach (tbl[n]) dut.U_imem.RAM[tbl[n].pc[9:2]] = tbl[n].instr;
        release_reset();
        foreach (tbl[n]) begin
            check($sformatf("tbl%0d_pc", n), pcW, tbl[n].pc);
            step();
            if (tbl[n].kind == 0)
                check($sformatf("tbl%0d_x%0d", n, tbl[n].idx), dut.rf[tbl[n].idx], tbl[n].val);
            else if (tbl[n].kind == 1)
                check($sformatf("tbl%0d_mem%0d", n, tbl[n].idx), dut.dmem[tbl[n].idx], tbl[n].val);
        end

        // ---- random programs against the reference model
        for (int p = 0; p < 4; p++) begin
            hold_reset();
            for (int k = 0; k < 8; k++) begin
                simm    = 12'(256 + 4 * k);
                prog[k] = {simm[11:5], 5'd0, 5'd0, 3'd2, simm[4:0], 7'h23};
            end
            for (int k = 8; k < 256; k++) prog[k] = rnd_instr();
            for (int k = 0; k < 256; k++) dut.U_imem.RAM[k] = prog[k];
            for (int k = 0; k < 32; k++) m_x[k] = 32'd0;
            for (int k = 0; k < 256; k++) m_mem[k] = 32'd0;
            m_pc = 32'd0;
            release_reset();
            for (int c = 0; c < 500; c++) begin
                check($sformatf("rand%0d_pc", p), pcW, m_pc);
                if (pcW !== m_pc) break;
                model_step(prog[m_pc[9:2]], w);
                step();
                if (w > 0) check($sformatf("rand%0d_x%0d", p, w), dut.rf[w], m_x[w]);
            end
            for (int k = 1; k < 32; k++)
                check($sformatf("rand%0d_final_x%0d", p, k), dut.rf[k], m_x[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
